// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot-load sequencer.
// Imported by the sequencer top and its UART receiver.
package boot_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } boot_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LINK = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling,
// one-cycle valid / framing-error pulses after the stop-bit sample.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1;
  logic          rx_s;
  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          valid_n;
  logic          ferr_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    sh_n    = sh;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      R_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = R_START;
      end
      R_START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          valid_n = rx_s;
          ferr_n  = !rx_s;
          state_n = rx_s ? R_IDLE : R_BREAK;
        end
      end
      R_BREAK: begin
        // a low stop bit leaves the line low; wait for idle before re-arming
        cnt_n = '0;
        if (rx_s) state_n = R_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= R_IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync1       <= rx;
      rx_s        <= sync1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      o_valid     <= valid_n;
      o_frame_err <= ferr_n;
    end
  end

  assign o_data = sh;

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot-load sequencer: receives a framed image over UART, writes it
// to instruction memory, then releases the core from reset.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int ADDR_W         = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 20 * CLKS_PER_BIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_i_boot,
  input  logic              io_i_rx,
  output logic              o_cpu_hold,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  boot_state_t   state;
  boot_state_t   state_n;
  logic [1:0]    err_n;

  logic          rx_v;
  logic [7:0]    rx_d;
  logic          rx_fe;

  logic          buf_full;
  logic [7:0]    buf_d;
  logic          byte_v;
  logic [7:0]    byte_d;

  logic [TW-1:0] tmr;
  logic          tmo;
  logic          tmr_clr;

  logic [7:0]    len_lo;
  logic [15:0]   len_full;
  logic          len_bad;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] wcnt;
  logic [ADDR_W:0] wcnt_inc;
  logic          last_word;
  logic [1:0]    bcnt;
  logic [7:0]    csum;

  logic          busy_st;
  logic          overrun;
  logic          link_err;
  logic          hit_sync;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (io_i_rx),
    .o_valid    (rx_v),
    .o_data     (rx_d),
    .o_frame_err(rx_fe)
  );

  assign busy_st = (state == S_LEN0) || (state == S_LEN1) ||
                   (state == S_DATA) || (state == S_WRITE) ||
                   (state == S_CSUM);

  // bytes are held back while a word is being written
  assign byte_v = (state != S_WRITE) && (buf_full || rx_v);
  assign byte_d = buf_full ? buf_d : rx_d;

  assign overrun  = (state == S_WRITE) && rx_v && buf_full;
  assign tmo      = (tmr == TW'(TIMEOUT_CYCLES));
  assign tmr_clr  = !busy_st || rx_v;
  assign link_err = busy_st && (rx_fe || overrun || tmo);

  assign hit_sync = ((state == S_SYNC) || (state == S_ERROR)) &&
                    byte_v && (byte_d == SYNC_BYTE);

  assign len_full  = {byte_d, len_lo};
  assign len_bad   = (len_full == 16'd0) ||
                     (len_full > 16'(MAX_WORDS));
  assign wcnt_inc  = wcnt + (ADDR_W+1)'(1);
  assign last_word = (wcnt_inc == len);

  always_comb begin
    state_n = state;
    err_n   = ERR_NONE;
    unique case (state)
      S_IDLE: state_n = io_i_boot ? S_SYNC : S_RUN;
      S_RUN:  state_n = S_RUN;
      S_DONE: state_n = S_DONE;
      S_SYNC, S_ERROR: begin
        if (hit_sync) state_n = S_LEN0;
      end
      S_LEN0: begin
        if (byte_v) state_n = S_LEN1;
      end
      S_LEN1: begin
        if (byte_v) begin
          if (len_bad) begin
            state_n = S_ERROR;
            err_n   = ERR_LEN;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_v && bcnt == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: begin
        if (i_mem_ack) state_n = last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (byte_v) begin
          if (byte_d == csum) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ERROR;
            err_n   = ERR_CSUM;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (link_err) begin
      state_n = S_ERROR;
      err_n   = ERR_LINK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      buf_full    <= 1'b0;
      buf_d       <= '0;
      tmr         <= '0;
      len_lo      <= '0;
      len         <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      csum        <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_done      <= 1'b0;
      o_err       <= ERR_NONE;
    end else begin
      state <= state_n;

      if (tmr_clr) tmr <= '0;
      else if (!tmo) tmr <= tmr + TW'(1);

      if (state == S_WRITE) begin
        if (rx_v && !buf_full) begin
          buf_d    <= rx_d;
          buf_full <= 1'b1;
        end
      end else if (buf_full) begin
        if (rx_v) buf_d <= rx_d;
        else buf_full <= 1'b0;
      end
      if (state_n == S_ERROR) buf_full <= 1'b0;

      if (hit_sync) begin
        o_err      <= ERR_NONE;
        o_done     <= 1'b0;
        o_mem_addr <= '0;
        wcnt       <= '0;
        bcnt       <= '0;
        csum       <= '0;
      end

      if (state != S_ERROR && state_n == S_ERROR) o_err <= err_n;

      if (state == S_LEN0 && byte_v) len_lo <= byte_d;
      if (state == S_LEN1 && byte_v) len <= len_full[ADDR_W:0];

      if (state == S_DATA && byte_v) begin
        o_mem_wdata <= {byte_d, o_mem_wdata[31:8]};
        csum        <= csum + byte_d;
        bcnt        <= bcnt + 2'd1;
      end

      if (state == S_WRITE && i_mem_ack) begin
        wcnt <= wcnt_inc;
        if (!last_word) o_mem_addr <= o_mem_addr + ADDR_W'(1);
      end

      if (state == S_CSUM && state_n == S_DONE) o_done <= 1'b1;
    end
  end

  assign o_cpu_hold = !((state == S_RUN) || (state == S_DONE));
  assign o_mem_req  = (state == S_WRITE);
  assign o_busy     = busy_st;

endmodule
